spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
Synthesizable SPI flash target, mode 0, single-bit. Answers the Microwatt SPI flash controller's boot reads from an on-chip byte-wide memory, so the openframe design can boot with no external flash chip.
- Sits on the flash pins: spi_flash_cs_n, spi_flash_clk, sdat[0] as MOSI, sdat[1] as MISO.
- All SPI inputs are oversampled in the ext_clk domain; no logic is clocked by SCLK.

Parameters:
ADDR_W, 24, byte address width presented to memory (flash address field is always 24 bits; upper bits are dropped if ADDR_W < 24).
JEDEC_ID, 24'hEF4018, bytes returned by RDID, MSB first.
SYNC_STAGES, 2, synchronizer depth on cs_n/sclk/mosi (min 2).

Ports:
ext_clk  input  1  system clock.
ext_rst  input  1  synchronous, active-high reset.
spi_cs_n  input  1  chip select, active low, asynchronous to ext_clk.
spi_clk  input  1  SCLK; idles low (mode 0).
spi_mosi  input  1  serial data from initiator.
spi_miso  output  1  serial data to initiator.
spi_miso_oe  output  1  MISO drive enable (pad oeb = ~oe).
mem_rd  output  1  one-cycle read strobe.
mem_addr  output  ADDR_W  byte address for mem_rd.
mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd.
busy  output  1  high while CS is active (synchronized).

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, mem_rd=0, mem_addr=0, busy=0, FSM=IDLE, synchronizers cleared to idle levels (cs_n=1, sclk=0).
- Synchronization and edge detection:
  - Each input passes SYNC_STAGES flops.
  - A registered copy of synced sclk/cs_n gives rise, fall, cs_fall and cs_rise pulses.
  - Edge-to-action latency: SYNC_STAGES+1 cycles.
  - Supported SCLK: each half-period ≥ SYNC_STAGES+4 ext_clk cycles.
- Bit timing: MOSI is sampled on detected rise. MISO changes on detected fall, registered, visible 1 cycle later.
- cs_rise in any state: go to IDLE, miso_oe=0, clear bit counter. This is the only abort path. A new command always starts at cs_fall.
- States:
  - IDLE: on cs_fall, go to CMD with bit count 0.
  - CMD: shift 8 bits MSB first. On 8th rise, decode:
    - 0x03 goes to ADDR.
    - 0x9F goes to ID, loading JEDEC_ID into a 24-bit shift register.
    - 0x05 goes to STATUS.
    - Anything else goes to IGNORE.
  - ADDR: shift 24 bits. The cycle after the 24th rise: mem_rd=1 with mem_addr=addr[ADDR_W-1:0]. The next cycle: load mem_rdata into the tx shift register and set ptr=addr+1. Then go to DATA.
  - DATA:
    - On each fall: miso_oe=1 and miso=tx[7]. The first fall after ADDR drives bit 7 without shifting; later falls shift, then drive.
    - On the fall that drives bit 7 of a byte: issue mem_rd at ptr, capture into the prefetch register next cycle, ptr += 1.
    - After 8 bits are driven, the next fall loads the prefetch byte into tx and drives its MSB.
    - ptr wraps modulo 2^24 (0xFFFFFF → 0x000000), then truncates to ADDR_W.
  - ID: same drive rules, sourced from the 24-bit ID register. After 24 bits, drive 0x00 until CS rises.
  - STATUS: drive 0x00 repeatedly (never busy, WEL=0).
  - IGNORE: miso_oe=0, ignore SCLK until cs_rise.
- Simultaneous events: cs_rise wins over any SCLK edge in the same cycle. Reset wins over everything.
- busy = synced ~cs_n.
- Reset mid-transfer: same as reset values above. The host must deassert CS before the next command.

Decomposition:
- Shared package spi_flash_pkg holds:
  - Command constants CMD_READ=8'h03, CMD_RDID=8'h9F, CMD_RDSR=8'h05.
  - FSM state enum {IDLE, CMD, ADDR, DATA, ID, STATUS, IGNORE}.
  - FLASH_ADDR_BITS=24.
- One natural sub-module: spi_flash_sync_edge, a per-signal synchronizer plus rise/fall detector, instantiated three times (cs_n, sclk, mosi; mosi without edge outputs).

Test Plan:
- Reset, then idle for 20 cycles → miso_oe=0, mem_rd never asserted, busy=0.
- Memory preloaded mem[i]=i[7:0]; send READ 0x03, addr 0x000010, clock 32 data bits → MISO bytes 0x10,0x11,0x12,0x13; mem_rd addresses 0x10..0x14, each a 1-cycle pulse.
- RDID 0x9F, 40 data bits → 0xEF,0x40,0x18,0x00,0x00.
- Unknown command 0xFF, 16 further SCLKs → miso_oe stays 0. Then CS high, RDSR 0x05 → 0x00 with miso_oe=1.
- READ with CS deasserted after 10 address bits, then a fresh READ at 0x000020 → first byte 0x20, no stray mem_rd from the aborted command.
- Wrap (ADDR_W=24): READ at 0xFFFFFE, 3 bytes → mem_addr sequence 0xFFFFFE, 0xFFFFFF, 0x000000.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI flash responder.
package spi_flash_pkg;

   localparam int unsigned FLASH_ADDR_BITS = 24;

   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_RDID = 8'h9F;
   localparam logic [7:0] CMD_RDSR = 8'h05;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StData,
      StId,
      StStatus,
      StIgnore
   } state_e;

   function automatic state_e cmd_next_state(input logic [7:0] cmd);
      case (cmd)
         CMD_READ: return StAddr;
         CMD_RDID: return StId;
         CMD_RDSR: return StStatus;
         default:  return StIgnore;
      endcase
   endfunction

endpackage

// File: rtl/spi_flash_sync_edge.sv
// Multi-flop synchronizer with registered-copy rise/fall detection.
module spi_flash_sync_edge #(
   parameter int unsigned Stages  = 2,
   parameter bit          IdleVal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [Stages-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {Stages{IdleVal}};
         prev_q <= IdleVal;
      end else begin
         sync_q <= {sync_q[Stages-2:0], d_i};
         prev_q <= sync_q[Stages-1];
      end
   end

   assign q_o    = sync_q[Stages-1];
   assign rise_o = sync_q[Stages-1] & ~prev_q;
   assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 single-bit SPI flash target serving READ/RDID/RDSR from a byte-wide memory.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int unsigned ADDR_W      = 24,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              ext_clk,
   input  logic              ext_rst,
   input  logic              spi_cs_n,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   logic cs_n_s, cs_rise, cs_fall;
   logic sclk_s, sclk_rise, sclk_fall;
   logic mosi_s, unused_mosi_rise, unused_mosi_fall, unused_sclk_level;

   spi_flash_sync_edge #(.Stages(SYNC_STAGES), .IdleVal(1'b1)) u_sync_cs (
      .clk_i  (ext_clk),
      .rst_i  (ext_rst),
      .d_i    (spi_cs_n),
      .q_o    (cs_n_s),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   spi_flash_sync_edge #(.Stages(SYNC_STAGES), .IdleVal(1'b0)) u_sync_sclk (
      .clk_i  (ext_clk),
      .rst_i  (ext_rst),
      .d_i    (spi_clk),
      .q_o    (sclk_s),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   spi_flash_sync_edge #(.Stages(SYNC_STAGES), .IdleVal(1'b0)) u_sync_mosi (
      .clk_i  (ext_clk),
      .rst_i  (ext_rst),
      .d_i    (spi_mosi),
      .q_o    (mosi_s),
      .rise_o (unused_mosi_rise),
      .fall_o (unused_mosi_fall)
   );

   assign unused_sclk_level = sclk_s;

   state_e                     state_q;
   logic [4:0]                 bit_cnt_q;
   logic [22:0]                shift_q;
   logic [23:0]                shift_in;
   logic [7:0]                 tx_q;
   logic [7:0]                 prefetch_q;
   logic [23:0]                id_q;
   logic [FLASH_ADDR_BITS-1:0] ptr_q;
   logic                       first_q;
   logic                       load_tx_q;
   logic                       rd_pend_q;
   logic                       mem_rd_q;
   logic [ADDR_W-1:0]          mem_addr_q;
   logic                       miso_q;
   logic                       oe_q;

   assign shift_in = {shift_q, mosi_s};

   always_ff @(posedge ext_clk) begin
      if (ext_rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= '0;
         prefetch_q <= '0;
         id_q       <= '0;
         ptr_q      <= '0;
         first_q    <= 1'b0;
         load_tx_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
      end else begin
         mem_rd_q  <= 1'b0;
         rd_pend_q <= mem_rd_q;
         // Read data is valid the cycle after the strobe; steer it to tx or prefetch.
         if (rd_pend_q) begin
            if (load_tx_q) tx_q <= mem_rdata;
            else           prefetch_q <= mem_rdata;
            load_tx_q <= 1'b0;
         end

         if (cs_rise) begin
            state_q   <= StIdle;
            oe_q      <= 1'b0;
            bit_cnt_q <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (cs_fall) begin
                     state_q   <= StCmd;
                     bit_cnt_q <= '0;
                  end
               end
               StCmd: begin
                  if (sclk_rise) begin
                     shift_q <= shift_in[22:0];
                     if (bit_cnt_q == 5'd7) begin
                        bit_cnt_q <= '0;
                        state_q   <= cmd_next_state(shift_in[7:0]);
                        id_q      <= JEDEC_ID;
                        first_q   <= 1'b1;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
               end
               StAddr: begin
                  if (sclk_rise) begin
                     shift_q <= shift_in[22:0];
                     if (bit_cnt_q == 5'd23) begin
                        bit_cnt_q  <= '0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= shift_in[ADDR_W-1:0];
                        ptr_q      <= shift_in + 24'd1;
                        load_tx_q  <= 1'b1;
                        first_q    <= 1'b1;
                        state_q    <= StData;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
               end
               StData: begin
                  if (sclk_fall) begin
                     oe_q <= 1'b1;
                     if (first_q || bit_cnt_q == 5'd7) begin
                        // Byte boundary: drive the MSB and fetch the following byte.
                        if (first_q) begin
                           miso_q <= tx_q[7];
                        end else begin
                           tx_q   <= prefetch_q;
                           miso_q <= prefetch_q[7];
                        end
                        first_q    <= 1'b0;
                        bit_cnt_q  <= '0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= ptr_q[ADDR_W-1:0];
                        ptr_q      <= ptr_q + 24'd1;
                     end else begin
                        tx_q      <= {tx_q[6:0], 1'b0};
                        miso_q    <= tx_q[6];
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
               end
               StId: begin
                  if (sclk_fall) begin
                     oe_q <= 1'b1;
                     if (first_q) begin
                        miso_q  <= id_q[23];
                        first_q <= 1'b0;
                     end else begin
                        id_q   <= {id_q[22:0], 1'b0};
                        miso_q <= id_q[22];
                     end
                  end
               end
               StStatus: begin
                  if (sclk_fall) begin
                     oe_q   <= 1'b1;
                     miso_q <= 1'b0;
                  end
               end
               StIgnore: begin
                  oe_q <= 1'b0;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;
   assign busy        = ~cs_n_s;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed plus randomized bench for spi_flash_responder against a byte-level flash model.
module tb_spi_flash_responder;

   localparam int unsigned AW = 24;
   localparam logic [23:0] JID = 24'hEF4018;

   logic          ext_clk = 1'b0;
   logic          ext_rst;
   logic          spi_cs_n;
   logic          spi_clk;
   logic          spi_mosi;
   logic          spi_miso;
   logic          spi_miso_oe;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          busy;

   int          checks    = 0;
   int          failures  = 0;
   int          half      = 6;
   int          rd_double = 0;
   logic        rd_prev   = 1'b0;
   logic [23:0] rd_log[$];

   always #5 ext_clk = ~ext_clk;

   spi_flash_responder #(
      .ADDR_W      (AW),
      .JEDEC_ID    (JID),
      .SYNC_STAGES (2)
   ) dut (
      .ext_clk     (ext_clk),
      .ext_rst     (ext_rst),
      .spi_cs_n    (spi_cs_n),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .busy        (busy)
   );

   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      return a[7:0];
   endfunction

   // Memory returns data only in the cycle after a strobe; junk otherwise.
   always @(posedge ext_clk) begin
      mem_rdata <= mem_rd ? mem_byte(mem_addr) : 8'($urandom);
   end

   always @(negedge ext_clk) begin
      if (mem_rd) begin
         rd_log.push_back(mem_addr);
         if (rd_prev) rd_double++;
      end
      rd_prev = mem_rd;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge ext_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic spi_bit(input logic mo, output logic mi, output logic oe, input bit end_cs);
      spi_mosi = mo;
      tick(half);
      mi = spi_miso;
      oe = spi_miso_oe;
      spi_clk = 1'b1;
      tick(half);
      spi_clk = 1'b0;
      if (end_cs) spi_cs_n = 1'b1;
   endtask

   task automatic spi_byte(input logic [7:0] txb, output logic [7:0] rxb, output logic oe_all,
                           output logic oe_any, input bit end_cs);
      logic mi, oe;
      oe_all = 1'b1;
      oe_any = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(txb[i], mi, oe, end_cs && i == 0);
         rxb[i] = mi;
         oe_all = oe_all & oe;
         oe_any = oe_any | oe;
      end
   endtask

   task automatic cs_start();
      half = 6 + int'($urandom_range(0, 3));
      spi_cs_n = 1'b0;
      tick(half);
   endtask

   task automatic do_read(input logic [23:0] a, input int n, input string tag);
      logic [7:0] rx;
      logic       oa, on;
      rd_log.delete();
      cs_start();
      spi_byte(8'h03, rx, oa, on, 1'b0);
      spi_byte(a[23:16], rx, oa, on, 1'b0);
      spi_byte(a[15:8], rx, oa, on, 1'b0);
      spi_byte(a[7:0], rx, oa, on, 1'b0);
      for (int k = 0; k < n; k++) begin
         spi_byte(8'h00, rx, oa, on, k == n - 1);
         check($sformatf("%s_byte%0d", tag, k), {24'h0, rx}, {24'h0, mem_byte(24'(a + k))});
         check($sformatf("%s_oe%0d", tag, k), {31'h0, oa}, 32'h1);
      end
      tick(12);
      // One read for the address phase plus one per byte boundary before CS rises.
      check($sformatf("%s_nreads", tag), rd_log.size(), n + 1);
      for (int j = 0; j < rd_log.size() && j <= n; j++) begin
         check($sformatf("%s_rdaddr%0d", tag, j), {8'h0, rd_log[j]}, {8'h0, 24'(a + j)});
      end
   endtask

   initial begin
      logic [7:0]  rx;
      logic        oa, on, mi, oe;
      logic [23:0] ra;

      ext_rst  = 1'b1;
      spi_cs_n = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      tick(4);
      ext_rst = 1'b0;
      rd_log.delete();
      tick(20);
      check("reset_oe", {31'h0, spi_miso_oe}, 32'h0);
      check("reset_miso", {31'h0, spi_miso}, 32'h0);
      check("reset_busy", {31'h0, busy}, 32'h0);
      check("reset_addr", {8'h0, mem_addr}, 32'h0);
      check("idle_no_rd", rd_log.size(), 0);

      do_read(24'h000010, 4, "read10");

      // RDID: three ID bytes then zeros.
      cs_start();
      tick(2);
      check("busy_active", {31'h0, busy}, 32'h1);
      spi_byte(8'h9F, rx, oa, on, 1'b0);
      for (int k = 0; k < 5; k++) begin
         spi_byte(8'h00, rx, oa, on, k == 4);
         check($sformatf("rdid_byte%0d", k), {24'h0, rx},
               (k < 3) ? {24'h0, JID[23 - 8 * k -: 8]} : 32'h0);
         check($sformatf("rdid_oe%0d", k), {31'h0, oa}, 32'h1);
      end
      tick(12);
      check("busy_released", {31'h0, busy}, 32'h0);

      // Unknown command leaves MISO undriven.
      rd_log.delete();
      cs_start();
      spi_byte(8'hFF, rx, oa, on, 1'b0);
      spi_byte(8'h00, rx, oa, on, 1'b0);
      check("ignore_oe_b0", {31'h0, on}, 32'h0);
      spi_byte(8'h00, rx, oa, on, 1'b1);
      check("ignore_oe_b1", {31'h0, on}, 32'h0);
      tick(12);
      check("ignore_no_rd", rd_log.size(), 0);

      cs_start();
      spi_byte(8'h05, rx, oa, on, 1'b0);
      for (int k = 0; k < 2; k++) begin
         spi_byte(8'h00, rx, oa, on, k == 1);
         check($sformatf("rdsr_byte%0d", k), {24'h0, rx}, 32'h0);
         check($sformatf("rdsr_oe%0d", k), {31'h0, oa}, 32'h1);
      end
      tick(12);

      // Abort a READ after 10 address bits.
      rd_log.delete();
      cs_start();
      spi_byte(8'h03, rx, oa, on, 1'b0);
      for (int i = 0; i < 10; i++) spi_bit(1'b1, mi, oe, i == 9);
      tick(12);
      check("abort_no_rd", rd_log.size(), 0);
      check("abort_oe", {31'h0, spi_miso_oe}, 32'h0);
      do_read(24'h000020, 1, "read20");

      do_read(24'hFFFFFE, 3, "wrap");

      for (int t = 0; t < 4; t++) begin
         ra = 24'($urandom);
         do_read(ra, int'($urandom_range(1, 3)), $sformatf("rnd%0d", t));
      end

      // Reset in the middle of an RDID.
      cs_start();
      spi_byte(8'h9F, rx, oa, on, 1'b0);
      spi_byte(8'h00, rx, oa, on, 1'b0);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, mi, oe, 1'b0);
      ext_rst = 1'b1;
      tick(1);
      ext_rst = 1'b0;
      check("midrst_oe", {31'h0, spi_miso_oe}, 32'h0);
      check("midrst_rd", {31'h0, mem_rd}, 32'h0);
      check("midrst_busy", {31'h0, busy}, 32'h0);
      spi_cs_n = 1'b1;
      tick(12);
      do_read(24'h000123, 2, "postrst");

      check("rd_single_cycle", rd_double, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
